arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
- Parametrised player-input front end for arcade cores: merges PS/2 key events and two MiSTer joysticks into per-player direction/button/start/coin signals.
- Adds selectable 4-way rotation, per-button autofire and a debounced fixed-width coin pulse generator.
- Sits between hps_io and the arcade core top. Replaces ad-hoc per-core key decoding in emu.

Parameters:
- NUM_BTN, 2, fire buttons per player (1..4).
- COIN_PULSE_CYCLES, 2400000, coin pulse width in clk_sys cycles (≈100 ms at 24 MHz). Must be ≥1.
- AUTOFIRE_FRAMES, 3, ce_frame pulses per autofire half-period (≥1).
- COIN_ON_START, 0, if 1 a start request also raises the coin request for that player.

Ports:
- clk_sys  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  65  hps_io key event: [64] toggle, [15:8] F0 = release, E0 = extended prefix, [63:24] non-zero = PRNSCR/PAUSE (ignored).
- joystick_0, joystick_1  in  16 each  layout: [0] right, [1] left, [2] down, [3] up, [4+:NUM_BTN] fire, [4+NUM_BTN] start, [5+NUM_BTN] coin.
- rotate  in  2  0 none, 1 CW, 2 CCW, 3 180°.
- autofire_en  in  NUM_BTN  per-button autofire enable, shared by both players.
- ce_frame  in  1  one-cycle pulse per video frame (vblank rise).
- p1_dir, p2_dir  out  4  {up,down,left,right}, active high.
- p1_btn, p2_btn  out  NUM_BTN  fire buttons, active high.
- start1, start2, coin1, coin2  out  1  active high.

Behaviour:
- Reset: all key-state registers, outputs, counters and autofire phase are 0. Coin FSMs go to IDLE. Reset asserted mid-pulse ends the coin pulse immediately.
- PS/2 decode:
  - Event is accepted when ps2_key[64] differs from its registered copy.
  - pressed = ([15:8] != F0). Extended is taken from [23:16] on release and from [15:8] on press.
  - Codes with [63:24] != 0 are discarded.
  - The matched key-state bit is set to pressed. Unmapped codes change nothing.
  - Arrow matching ignores the extended flag.
- Key table (package): P1 arrows 75/72/6B/74; P1 fire0 029 or 014, fire1 011, fire2 012, fire3 01A; P2 R/F/D/G = 2D/2B/23/34; P2 fire0..3 01C/01B/015/01D; start F1 005 / F2 006; coin 02E ("5") / 036 ("6").
- Merge: raw = key_state | joystick bits for the matching player.
- Rotation, applied to dirs (U,D,L,R out):
  - 0 = U,D,L,R.
  - 1 = L,R,D,U.
  - 2 = R,L,U,D.
  - 3 = D,U,R,L.
  - rotate is sampled combinationally each cycle.
- Autofire:
  - phase toggles after every AUTOFIRE_FRAMES ce_frame pulses (counter wraps to 0).
  - btn = raw & (autofire_en[i] ? phase : 1).
  - phase runs freely and is not restarted on press.
- Coin FSM, per player:
  - req = raw coin | (COIN_ON_START & raw start).
  - IDLE: on req go to PULSE, load counter = COIN_PULSE_CYCLES-1, coin=1.
  - PULSE: decrement; at 0 go to HOLD, coin=0.
  - HOLD: wait for req=0, then IDLE.
  - A held or re-pressed request during PULSE/HOLD produces no extra pulse.
  - Exactly one pulse of COIN_PULSE_CYCLES cycles per request assertion.
- Latency:
  - Joystick to output: 1 clk (registered outputs).
  - PS/2 event to output: 2 clk (key-state reg + output reg).
  - Coin output asserts 1 clk after req is registered.
- Simultaneous events: a PS/2 event and joystick changes in the same cycle are both honoured (OR).

Decomposition:
- Package arcade_input_pkg: key-code localparams, joystick bit-index functions of NUM_BTN, rotate-mode enum, coin FSM state enum.
- Sub-module coin_pulser (one per player; params COIN_PULSE_CYCLES; ports clk_sys, reset_n, req, coin).

Test Plan:
- PS/2 press {E0,75} then release {F0,E0,75}, rotate=0 → p1_dir=1000 from 2 clk after toggle, 0000 2 clk after release toggle.
- joystick_0[3]=1, rotate=1 → p1_dir=0001 (right); rotate=2 → 0010 (left); rotate=3 → 0100 (down).
- Key 02E held 3×COIN_PULSE_CYCLES (set COIN_PULSE_CYCLES=10) → coin1 high exactly 10 cycles, once; release and press again → second 10-cycle pulse.
- COIN_ON_START=1, joystick_1 start bit pulsed → start2=1 and one 10-cycle coin2 pulse.
- autofire_en[0]=1, AUTOFIRE_FRAMES=3, fire held, 12 ce_frame pulses → p1_btn[0] toggles every 3 frames (2 high periods). autofire_en=0 → constant 1.
- reset_n low during coin PULSE → coin1=0 immediately; after release with req still held → new pulse starts (FSM in IDLE).

Source files
------------

// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: PS/2 key codes, joystick bit layout, rotate and coin-FSM types
package arcade_input_pkg;
  localparam logic [7:0] PS2_REL = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  // arrows are matched on the 8-bit code alone; every other key on {extended, code}
  localparam logic [7:0] K_P1_UP    = 8'h75;
  localparam logic [7:0] K_P1_DOWN  = 8'h72;
  localparam logic [7:0] K_P1_LEFT  = 8'h6B;
  localparam logic [7:0] K_P1_RIGHT = 8'h74;
  localparam logic [8:0] K_P1_FIRE0_ALT = 9'h014;
  localparam logic [35:0] K_P1_FIRE = {9'h01A, 9'h012, 9'h011, 9'h029};
  localparam logic [8:0] K_P2_UP    = 9'h02D;
  localparam logic [8:0] K_P2_DOWN  = 9'h02B;
  localparam logic [8:0] K_P2_LEFT  = 9'h023;
  localparam logic [8:0] K_P2_RIGHT = 9'h034;
  localparam logic [35:0] K_P2_FIRE = {9'h01D, 9'h015, 9'h01B, 9'h01C};
  localparam logic [8:0] K_START1 = 9'h005;
  localparam logic [8:0] K_START2 = 9'h006;
  localparam logic [8:0] K_COIN1  = 9'h02E;
  localparam logic [8:0] K_COIN2  = 9'h036;
  typedef enum logic [1:0] {ROT_NONE, ROT_CW, ROT_CCW, ROT_180} rot_e;
  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_HOLD} coin_state_e;
  function automatic int jfire(input int i);
    return 4 + i;
  endfunction
  function automatic int jstart(input int n);
    return 4 + n;
  endfunction
  function automatic int jcoin(input int n);
    return 5 + n;
  endfunction
  // d and result are {up,down,left,right}
  function automatic logic [3:0] rot_dir(input logic [3:0] d, input rot_e m);
    return m == ROT_CW  ? {d[1], d[0], d[2], d[3]} :
           m == ROT_CCW ? {d[0], d[1], d[3], d[2]} :
           m == ROT_180 ? {d[2], d[3], d[0], d[1]} : d;
  endfunction
endpackage

// File: rtl/coin_pulser.sv
// coin_pulser: one fixed-width coin pulse per request assertion
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 2400000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin
);
  localparam int CW = COIN_PULSE_CYCLES > 1 ? $clog2(COIN_PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] C_LOAD = CW'(COIN_PULSE_CYCLES - 1);
  coin_state_e r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= C_IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
    end
  end
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    case (r_state)
      C_IDLE: if (req) begin
        w_next = C_PULSE;
        w_cnt = C_LOAD;
      end
      C_PULSE: if (r_cnt == '0) w_next = C_HOLD; else w_cnt = r_cnt - 1'b1;
      C_HOLD: if (!req) w_next = C_IDLE;
      default: w_next = C_IDLE;
    endcase
  end
  assign coin = r_state == C_PULSE;
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges PS/2 keys and two joysticks into per-player arcade controls
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_BTN = 2,
  parameter int COIN_PULSE_CYCLES = 2400000,
  parameter int AUTOFIRE_FRAMES = 3,
  parameter int COIN_ON_START = 0
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [64:0]        ps2_key,
  input  logic [15:0]        joystick_0,
  input  logic [15:0]        joystick_1,
  input  logic [1:0]         rotate,
  input  logic [NUM_BTN-1:0] autofire_en,
  input  logic               ce_frame,
  output logic [3:0]         p1_dir,
  output logic [3:0]         p2_dir,
  output logic [NUM_BTN-1:0] p1_btn,
  output logic [NUM_BTN-1:0] p2_btn,
  output logic               start1,
  output logic               start2,
  output logic               coin1,
  output logic               coin2
);
  localparam int AW = AUTOFIRE_FRAMES > 1 ? $clog2(AUTOFIRE_FRAMES) : 1;
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_FRAMES - 1);
  localparam int JF = jfire(0);
  localparam int JS = jstart(NUM_BTN);
  localparam int JC = jcoin(NUM_BTN);
  localparam int KS = 2 * NUM_BTN + 12;
  // key-state layout: {coin[1:0], start[1:0], p2 btn, p2 dir, p1 btn, p1 dir}
  logic r_tgl, r_phase;
  logic [AW-1:0] r_af_cnt;
  logic [KS-1:0] r_ks, w_hit;
  logic w_ev, w_pr;
  logic [8:0] w_key;
  logic [3:0] w_h1_dir, w_h2_dir, w_raw1_dir, w_raw2_dir;
  logic [NUM_BTN-1:0] w_h1_btn, w_h2_btn, w_raw1_btn, w_raw2_btn, w_af_mask;
  logic [1:0] w_start, w_coin, w_coin_req;
  logic w_unused;
  always_comb begin
    w_ev = ps2_key[64] != r_tgl && ps2_key[63:24] == '0;
    w_pr = ps2_key[15:8] != PS2_REL;
    w_key = {w_pr ? ps2_key[15:8] == PS2_EXT : ps2_key[23:16] == PS2_EXT, ps2_key[7:0]};
    w_h1_dir = w_ev ? {ps2_key[7:0] == K_P1_UP, ps2_key[7:0] == K_P1_DOWN,
                       ps2_key[7:0] == K_P1_LEFT, ps2_key[7:0] == K_P1_RIGHT} : 4'b0;
    w_h2_dir = w_ev ? {w_key == K_P2_UP, w_key == K_P2_DOWN,
                       w_key == K_P2_LEFT, w_key == K_P2_RIGHT} : 4'b0;
    w_h1_btn = '0;
    w_h2_btn = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_h1_btn[i] = w_ev && (w_key == K_P1_FIRE[9*i+:9] || (i == 0 && w_key == K_P1_FIRE0_ALT));
      w_h2_btn[i] = w_ev && w_key == K_P2_FIRE[9*i+:9];
    end
    w_hit = {w_ev && w_key == K_COIN2, w_ev && w_key == K_COIN1,
             w_ev && w_key == K_START2, w_ev && w_key == K_START1,
             w_h2_btn, w_h2_dir, w_h1_btn, w_h1_dir};
  end
  assign w_raw1_dir = r_ks[3:0] | joystick_0[3:0];
  assign w_raw1_btn = r_ks[4+:NUM_BTN] | joystick_0[JF+:NUM_BTN];
  assign w_raw2_dir = r_ks[4+NUM_BTN+:4] | joystick_1[3:0];
  assign w_raw2_btn = r_ks[8+NUM_BTN+:NUM_BTN] | joystick_1[JF+:NUM_BTN];
  assign w_start = r_ks[8+2*NUM_BTN+:2] | {joystick_1[JS], joystick_0[JS]};
  assign w_coin = r_ks[10+2*NUM_BTN+:2] | {joystick_1[JC], joystick_0[JC]};
  assign w_coin_req = w_coin | (COIN_ON_START != 0 ? w_start : 2'b00);
  assign w_af_mask = ~autofire_en | {NUM_BTN{r_phase}};
  assign w_unused = &{1'b0, joystick_0[15:JC+1], joystick_1[15:JC+1]};
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tgl <= 1'b0;
      r_ks <= '0;
      r_af_cnt <= '0;
      r_phase <= 1'b0;
      p1_dir <= '0;
      p2_dir <= '0;
      p1_btn <= '0;
      p2_btn <= '0;
      start1 <= 1'b0;
      start2 <= 1'b0;
    end else begin
      r_tgl <= ps2_key[64];
      r_ks <= w_pr ? r_ks | w_hit : r_ks & ~w_hit;
      if (ce_frame) begin
        r_af_cnt <= r_af_cnt == AF_LAST ? '0 : r_af_cnt + 1'b1;
        if (r_af_cnt == AF_LAST) r_phase <= ~r_phase;
      end
      p1_dir <= rot_dir(w_raw1_dir, rot_e'(rotate));
      p2_dir <= rot_dir(w_raw2_dir, rot_e'(rotate));
      p1_btn <= w_raw1_btn & w_af_mask;
      p2_btn <= w_raw2_btn & w_af_mask;
      start1 <= w_start[0];
      start2 <= w_start[1];
    end
  end
  coin_pulser #(.COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)) u_coin1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(w_coin_req[0]), .coin(coin1)
  );
  coin_pulser #(.COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)) u_coin2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(w_coin_req[1]), .coin(coin2)
  );
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed tables and sequences plus a randomized reference-model run
module tb_arcade_input_mapper;
  localparam int NB = 4, CP = 10, AF = 3;
  logic clk = 1'b0, reset_n = 1'b1;
  logic [64:0] ps2_key = '0;
  logic [15:0] joystick_0 = '0, joystick_1 = '0;
  logic [1:0] rotate = '0;
  logic [NB-1:0] autofire_en = '0;
  logic ce_frame = 1'b0;
  logic [3:0] p1_dir, p2_dir;
  logic [NB-1:0] p1_btn, p2_btn;
  logic start1, start2, coin1, coin2;
  int nvec = 0, nmis = 0;

  arcade_input_mapper #(.NUM_BTN(NB), .COIN_PULSE_CYCLES(CP), .AUTOFIRE_FRAMES(AF), .COIN_ON_START(1)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick_0(joystick_0), .joystick_1(joystick_1),
    .rotate(rotate), .autofire_en(autofire_en), .ce_frame(ce_frame), .p1_dir(p1_dir), .p2_dir(p2_dir),
    .p1_btn(p1_btn), .p2_btn(p2_btn), .start1(start1), .start2(start2), .coin1(coin1), .coin2(coin2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] j0, j1;
    logic [1:0] rot;
    logic [3:0] e1, e2;
  } vec_t;
  vec_t tv[8];

  bit ks[20];
  int fmap[int];
  bit tgl_prev;
  int nfr;
  int left[2];
  bit waitr[2];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic key(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
    ps2_key = {~ps2_key[64], 40'd0, b2, b1, b0};
  endtask

  task automatic do_reset();
    ps2_key = '0;
    joystick_0 = '0;
    joystick_1 = '0;
    rotate = '0;
    autofire_en = '0;
    ce_frame = 1'b0;
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic count(input int n, input int sel, output int hi, output int rise);
    logic prev, cur;
    hi = 0;
    rise = 0;
    prev = sel == 0 ? coin1 : sel == 1 ? coin2 : p1_btn[0];
    for (int i = 0; i < n; i++) begin
      cyc();
      cur = sel == 0 ? coin1 : sel == 1 ? coin2 : p1_btn[0];
      if (cur) hi++;
      if (cur && !prev) rise++;
      prev = cur;
    end
  endtask

  // directions walked clockwise U,R,D,L; a rotation mode is a number of quarter turns
  function automatic logic [3:0] m_rot(input logic [3:0] d, input logic [1:0] m);
    int cwl[4];
    int k;
    logic [3:0] o;
    cwl = '{3, 0, 2, 1};
    k = m == 2'd1 ? 1 : m == 2'd2 ? 3 : m == 2'd3 ? 2 : 0;
    o = '0;
    for (int j = 0; j < 4; j++) if (d[cwl[j]]) o[cwl[(j + k) % 4]] = 1'b1;
    return o;
  endfunction

  task automatic model_step(output logic [19:0] e);
    logic [3:0] d1, d2, b1, b2;
    logic s1, s2, ph, pr, ext;
    logic [1:0] req;
    int k;
    d1 = {ks[0], ks[1], ks[2], ks[3]} | joystick_0[3:0];
    d2 = {ks[8], ks[9], ks[10], ks[11]} | joystick_1[3:0];
    ph = ((nfr / AF) % 2) == 1;
    for (int i = 0; i < 4; i++) begin
      b1[i] = (ks[4+i] | joystick_0[4+i]) & (autofire_en[i] ? ph : 1'b1);
      b2[i] = (ks[12+i] | joystick_1[4+i]) & (autofire_en[i] ? ph : 1'b1);
    end
    s1 = ks[16] | joystick_0[8];
    s2 = ks[17] | joystick_1[8];
    req = {ks[19] | joystick_1[9] | s2, ks[18] | joystick_0[9] | s1};
    for (int p = 0; p < 2; p++) begin
      if (left[p] > 0) left[p]--;
      else if (waitr[p]) begin
        if (!req[p]) waitr[p] = 1'b0;
      end else if (req[p]) begin
        left[p] = CP;
        waitr[p] = 1'b1;
      end
    end
    e = {m_rot(d1, rotate), m_rot(d2, rotate), b1, b2, s1, s2, left[0] > 0, left[1] > 0};
    if (ps2_key[64] != tgl_prev) begin
      tgl_prev = ps2_key[64];
      if (ps2_key[63:24] == '0) begin
        pr = ps2_key[15:8] != 8'hF0;
        ext = pr ? ps2_key[15:8] == 8'hE0 : ps2_key[23:16] == 8'hE0;
        k = int'(ps2_key[7:0]) + (ext ? 256 : 0);
        if (fmap.exists(k)) ks[fmap[k]] = pr;
      end
    end
    if (ce_frame) nfr++;
  endtask

  initial begin
    int hi, rise;
    int pool[25];
    logic [19:0] e;
    logic [8:0] kc;
    logic [7:0] b2, b1;
    logic ext, pr;

    tv[0] = '{16'h0008, 16'h0001, 2'd0, 4'b1000, 4'b0001};
    tv[1] = '{16'h0008, 16'h0001, 2'd1, 4'b0001, 4'b0100};
    tv[2] = '{16'h0008, 16'h0004, 2'd2, 4'b0010, 4'b0001};
    tv[3] = '{16'h0008, 16'h000A, 2'd3, 4'b0100, 4'b0101};
    tv[4] = '{16'h000A, 16'h0000, 2'd0, 4'b1010, 4'b0000};
    tv[5] = '{16'h0004, 16'h0002, 2'd1, 4'b0010, 4'b1000};
    tv[6] = '{16'h0001, 16'h000F, 2'd2, 4'b1000, 4'b1111};
    tv[7] = '{16'h0003, 16'h000C, 2'd3, 4'b0011, 4'b1100};
    for (int x = 0; x < 2; x++) begin
      fmap['h75 + 256*x] = 0; fmap['h72 + 256*x] = 1; fmap['h6B + 256*x] = 2; fmap['h74 + 256*x] = 3;
    end
    fmap['h029] = 4; fmap['h014] = 4; fmap['h011] = 5; fmap['h012] = 6; fmap['h01A] = 7;
    fmap['h02D] = 8; fmap['h02B] = 9; fmap['h023] = 10; fmap['h034] = 11;
    fmap['h01C] = 12; fmap['h01B] = 13; fmap['h015] = 14; fmap['h01D] = 15;
    fmap['h005] = 16; fmap['h006] = 17; fmap['h02E] = 18; fmap['h036] = 19;
    pool = '{'h175, 'h172, 'h16B, 'h174, 'h029, 'h014, 'h011, 'h012, 'h01A, 'h02D, 'h02B, 'h023, 'h034,
             'h01C, 'h01B, 'h015, 'h01D, 'h005, 'h006, 'h02E, 'h036, 'h115, 'h114, 'h076, 'h03C};

    #2 reset_n = 1'b0;
    #1 chk("reset_async", {p1_dir, p2_dir, p1_btn, p2_btn, start1, start2, coin1, coin2}, 0);
    do_reset();
    chk("reset_state", {p1_dir, p2_dir, p1_btn, p2_btn, start1, start2, coin1, coin2}, 0);

    for (int i = 0; i < 8; i++) begin
      joystick_0 = tv[i].j0;
      joystick_1 = tv[i].j1;
      rotate = tv[i].rot;
      cyc();
      chk($sformatf("joy_rot[%0d]", i), {p1_dir, p2_dir}, {tv[i].e1, tv[i].e2});
    end
    joystick_0 = '0;
    joystick_1 = '0;
    rotate = '0;
    cyc();

    key(8'h00, 8'hE0, 8'h75);
    cyc(); chk("ps2_press_lat1", p1_dir, 4'b0000);
    cyc(); chk("ps2_press_lat2", p1_dir, 4'b1000);
    key(8'hE0, 8'hF0, 8'h75);
    cyc(); chk("ps2_rel_lat1", p1_dir, 4'b1000);
    cyc(); chk("ps2_rel_lat2", p1_dir, 4'b0000);
    key(8'h00, 8'h00, 8'h72);
    cyc(); cyc(); chk("ps2_arrow_noext", p1_dir, 4'b0100);
    key(8'h00, 8'hF0, 8'h72);
    cyc(); cyc(); chk("ps2_arrow_noext_rel", p1_dir, 4'b0000);
    key(8'h00, 8'hE0, 8'h14);
    cyc(); cyc(); chk("ps2_ext_nomatch", p1_btn, 4'b0000);
    key(8'h00, 8'h00, 8'h14);
    cyc(); cyc(); chk("ps2_fire0_alt", p1_btn, 4'b0001);
    key(8'h00, 8'hF0, 8'h14);
    cyc(); cyc(); chk("ps2_fire0_rel", p1_btn, 4'b0000);
    ps2_key = {~ps2_key[64], 40'h0000000100, 8'h00, 8'h00, 8'h2E};
    cyc(); cyc(); cyc(); chk("ps2_discard", {start1, coin1}, 2'b00);

    key(8'h00, 8'h00, 8'h2E);
    count(3 * CP + 10, 0, hi, rise);
    chk("coin_held_width", hi, CP);
    chk("coin_held_once", rise, 1);
    key(8'h00, 8'hF0, 8'h2E);
    cyc(); cyc(); cyc();
    key(8'h00, 8'h00, 8'h2E);
    count(2 * CP, 0, hi, rise);
    chk("coin_repress_width", hi, CP);
    chk("coin_repress_once", rise, 1);
    key(8'h00, 8'hF0, 8'h2E);
    cyc(); cyc(); cyc();

    joystick_1[8] = 1'b1;
    cyc(); chk("start2", start2, 1'b1);
    chk("coin_on_start_lat", coin2, 1'b1);
    joystick_1[8] = 1'b0;
    count(2 * CP, 1, hi, rise);
    chk("coin_on_start_width", hi, CP - 1);
    chk("coin_on_start_once", rise, 0);
    cyc(); cyc();

    do_reset();
    autofire_en = 4'b0001;
    joystick_0[4] = 1'b1;
    hi = 0;
    rise = 0;
    begin
      logic prev;
      prev = p1_btn[0];
      for (int i = 0; i < 60; i++) begin
        ce_frame = i < 48 && i % 4 == 0;
        cyc();
        if (p1_btn[0]) hi++;
        if (p1_btn[0] && !prev) rise++;
        prev = p1_btn[0];
      end
    end
    ce_frame = 1'b0;
    chk("autofire_periods", rise, 2);
    chk("autofire_high_cycles", hi, 2 * AF * 4);
    autofire_en = '0;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      ce_frame = i % 2 == 0;
      cyc();
      if (p1_btn[0]) hi++;
    end
    ce_frame = 1'b0;
    chk("autofire_off_const", hi, 12);
    joystick_0[4] = 1'b0;
    cyc(); cyc();

    joystick_0[9] = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    chk("coin_mid_pulse", coin1, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk("coin_async_reset", coin1, 1'b0);
    cyc();
    reset_n = 1'b1;
    count(CP + 5, 0, hi, rise);
    chk("coin_after_reset_width", hi, CP);
    chk("coin_after_reset_once", rise, 1);
    joystick_0[9] = 1'b0;

    do_reset();
    for (int i = 0; i < 20; i++) ks[i] = 1'b0;
    tgl_prev = 1'b0;
    nfr = 0;
    left = '{0, 0};
    waitr = '{1'b0, 1'b0};
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(2) == 0) begin
        kc = 9'(pool[$urandom_range(24)]);
        pr = 1'($urandom_range(1));
        ext = kc[7:0] inside {8'h75, 8'h72, 8'h6B, 8'h74} ? 1'($urandom_range(1)) : kc[8];
        b1 = pr ? (ext ? 8'hE0 : 8'h00) : 8'hF0;
        b2 = pr ? 8'($urandom) : (ext ? 8'hE0 : 8'h00);
        ps2_key = {~ps2_key[64], ($urandom_range(15) == 0) ? 40'($urandom_range(255) + 1) : 40'd0, b2, b1, kc[7:0]};
      end else if ($urandom_range(3) == 0) ps2_key[63:0] = {$urandom, $urandom};
      if ($urandom_range(1) == 0) begin
        joystick_0 = 16'($urandom);
        joystick_0[8] = $urandom_range(7) == 0;
        joystick_0[9] = $urandom_range(7) == 0;
      end
      if ($urandom_range(1) == 0) begin
        joystick_1 = 16'($urandom);
        joystick_1[8] = $urandom_range(7) == 0;
        joystick_1[9] = $urandom_range(7) == 0;
      end
      if ($urandom_range(49) == 0) rotate = 2'($urandom);
      if ($urandom_range(99) == 0) autofire_en = 4'($urandom);
      ce_frame = $urandom_range(2) == 0;
      @(posedge clk);
      model_step(e);
      #1;
      chk("random", {p1_dir, p2_dir, p1_btn, p2_btn, start1, start2, coin1, coin2}, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
